// File: rtl/main_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : main_mem_responder
// Description : Block-granular main-memory responder. Accepts one-cycle
//               request pulses on the mem_req_* handshake, holds
//               mem_req_ready low for LATENCY cycles, then performs a
//               128-bit block read or write against an internal backing
//               store and raises mem_req_ready again.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   DEPTH_LOG2 - log2 of the number of 128-bit blocks in the backing store
//   LATENCY    - cycles mem_req_ready stays low per request (1..255)
// Ports:
//   clk            in   1    clock
//   rst_n          in   1    asynchronous active-low reset
//   mem_req_addr   in   32   byte address, block index = [DEPTH_LOG2+3:4]
//   mem_req_wdata  in   128  write block
//   mem_req_rw     in   1    1 = write, 0 = read
//   mem_req_valid  in   1    request strobe, sampled only in IDLE
//   mem_req_rdata  out  128  last completed read block
//   mem_req_ready  out  1    1 = idle / response complete, 0 = busy
//   rd_count       out  32   completed reads   (MAIN_MEM_STATS_EN only)
//   wr_count       out  32   completed writes  (MAIN_MEM_STATS_EN only)
// Optional feature macro: MAIN_MEM_STATS_EN
// ============================================================================
module main_mem_responder #(
    parameter int DEPTH_LOG2 = 12,
    parameter int LATENCY    = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [31:0]  mem_req_addr,
    input  logic [127:0] mem_req_wdata,
    input  logic         mem_req_rw,
    input  logic         mem_req_valid,
    output logic [127:0] mem_req_rdata,
    output logic         mem_req_ready
`ifdef MAIN_MEM_STATS_EN
    ,
    output logic [31:0]  rd_count,
    output logic [31:0]  wr_count
`endif
);

    localparam logic [0:0] c_S_IDLE = 1'b0;
    localparam logic [0:0] c_S_BUSY = 1'b1;
    localparam logic [7:0] c_LAT_M1 = 8'(LATENCY - 1);
    localparam int         c_BLOCKS = 1 << DEPTH_LOG2;

    logic [0:0]            state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic                  rw_q, rw_d;
    logic [127:0]          wdata_q, wdata_d;
    logic                  ready_q, ready_d;
    logic [127:0]          rdata_q, rdata_d;

    // Backing store: deliberately not reset, contents survive rst_n.
    logic [127:0]          mem_q [0:c_BLOCKS-1];

    logic                  w_complete;
    logic [127:0]          w_rd_block;
    logic                  w_unused_addr;

    // Address bits outside the block index alias onto the same block.
    assign w_unused_addr = ^{mem_req_addr[31:DEPTH_LOG2+4], mem_req_addr[3:0]};

    assign w_complete = (state_q == c_S_BUSY) && (cnt_q == 8'd0);
    assign w_rd_block = mem_q[idx_q];

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= c_S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_S_IDLE: if (mem_req_valid) state_d = c_S_BUSY;
            c_S_BUSY: if (cnt_q == 8'd0) state_d = c_S_IDLE;
            default:  state_d = c_S_IDLE;
        endcase
    end

    // --------------------------------------------------- outputs / datapath
    always_comb begin
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rw_d    = rw_q;
        wdata_d = wdata_q;
        ready_d = ready_q;
        rdata_d = rdata_q;
        case (state_q)
            c_S_IDLE: begin
                ready_d = 1'b1;
                if (mem_req_valid) begin
                    idx_d   = mem_req_addr[DEPTH_LOG2+3:4];
                    rw_d    = mem_req_rw;
                    wdata_d = mem_req_wdata;
                    cnt_d   = c_LAT_M1;
                    ready_d = 1'b0;
                end
            end
            c_S_BUSY: begin
                ready_d = 1'b0;
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    // Completion edge: ready rises with the access result.
                    ready_d = 1'b1;
                    if (!rw_q) rdata_d = w_rd_block;
                end
            end
            default: ready_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= 8'd0;
            idx_q   <= '0;
            rw_q    <= 1'b0;
            wdata_q <= '0;
            ready_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rw_q    <= rw_d;
            wdata_q <= wdata_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
        end
    end

    // Write commits only on the completion edge, so a reset arriving while
    // busy leaves the store untouched.
    always_ff @(posedge clk) begin
        if (w_complete && rw_q) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign mem_req_ready = ready_q;
    assign mem_req_rdata = rdata_q;

`ifdef MAIN_MEM_STATS_EN
    logic [31:0] rd_count_q, wr_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_count_q <= 32'd0;
            wr_count_q <= 32'd0;
        end else if (w_complete) begin
            if (rw_q) wr_count_q <= wr_count_q + 32'd1;
            else      rd_count_q <= rd_count_q + 32'd1;
        end
    end

    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
`endif

endmodule
`default_nettype wire
